// File: rtl/uart_rx_pkt_parser.sv
// Frames bytes drained from the UART receive buffer into SYNC + payload + checksum packets.
// Good packets update pkt_data with a one-cycle pkt_valid; aborted frames pulse pkt_err.
module uart_rx_pkt_parser #(
  parameter int unsigned NBYTES  = 4,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned TO_BIT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_empty,
  input  logic [7:0]          r_data,
  output logic                rd_uart,
  output logic [8*NBYTES-1:0] pkt_data,
  output logic                pkt_valid,
  output logic                pkt_err,
  output logic [1:0]          err_type
);

  typedef enum logic [1:0] {StHunt, StData, StCsum} state_e;

  localparam logic [TO_BIT-1:0] TLast = TO_BIT'(TIMEOUT - 1);
  localparam logic [2:0]        ILast = 3'(NBYTES - 1);

  state_e               state_q;
  logic                 rd_q;
  logic [2:0]           idx_q;
  logic [7:0]           sum_q;
  logic [TO_BIT-1:0]    tcnt_q;
  logic [8*NBYTES-1:0]  shadow_q;
  logic [5:0]           lsb;
  logic                 expired;

  // rd_q gating hides the buffer's one-cycle flag-clear latency.
  assign rd_uart = ~reset & ~rx_empty & ~rd_q;
  assign expired = ~rd_uart & (tcnt_q == TLast);
  // First payload byte lands in the MSBs.
  assign lsb     = {ILast - idx_q, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StHunt;
      rd_q      <= 1'b0;
      idx_q     <= 3'd0;
      sum_q     <= 8'h00;
      tcnt_q    <= '0;
      shadow_q  <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      err_type  <= 2'b00;
    end else begin
      rd_q      <= rd_uart;
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      unique case (state_q)
        StHunt: begin
          if (rd_uart && (r_data == SYNC)) begin
            state_q <= StData;
            idx_q   <= 3'd0;
            sum_q   <= 8'h00;
            tcnt_q  <= '0;
          end
        end
        StData: begin
          if (rd_uart) begin
            shadow_q[lsb +: 8] <= r_data;
            sum_q              <= sum_q + r_data;
            tcnt_q             <= '0;
            if (idx_q == ILast) begin
              state_q <= StCsum;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else if (expired) begin
            pkt_err  <= 1'b1;
            err_type <= 2'b10;
            state_q  <= StHunt;
          end else begin
            tcnt_q <= tcnt_q + TO_BIT'(1);
          end
        end
        StCsum: begin
          if (rd_uart) begin
            state_q <= StHunt;
            tcnt_q  <= '0;
            if (r_data == sum_q) begin
              pkt_data  <= shadow_q;
              pkt_valid <= 1'b1;
            end else begin
              pkt_err  <= 1'b1;
              err_type <= 2'b01;
            end
          end else if (expired) begin
            pkt_err  <= 1'b1;
            err_type <= 2'b10;
            state_q  <= StHunt;
          end else begin
            tcnt_q <= tcnt_q + TO_BIT'(1);
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// Directed bench for uart_rx_pkt_parser: a byte-queue buffer model feeds the DUT and a
// scoreboard of expected packets/errors is checked whenever a strobe appears.
module tb_uart_rx_pkt_parser;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic [31:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_err;
  logic [1:0]  err_type;

  uart_rx_pkt_parser #(
    .NBYTES (4),
    .SYNC   (8'hA5),
    .TIMEOUT(TO),
    .TO_BIT (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .pkt_data (pkt_data),
    .pkt_valid(pkt_valid),
    .pkt_err  (pkt_err),
    .err_type (err_type)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [1:0]  et;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  src[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_rd = -100;
  int          rd_count = 0;
  logic        take = 1'b0;
  logic [31:0] good = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic refresh();
    rx_empty = (src.size() == 0);
    r_data   = (src.size() > 0) ? src[0] : 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    src.push_back(b);
    refresh();
  endtask

  task automatic expect_pkt(input logic [31:0] d);
    sb.push_back('{1'b0, 2'b00, d, 1});
    good = d;
  endtask

  task automatic expect_err(input logic [1:0] t, input int lat);
    sb.push_back('{1'b1, t, good, lat});
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() > 0 || src.size() > 0) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain_bound", (n < 1000), 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_src_empty();
    int n = 0;
    while (src.size() > 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("src_empty_bound", (n < 200), 1);
  endtask

  // Receive buffer model: a byte is removed at the edge closing its rd_uart cycle.
  initial forever begin
    @(negedge clk);
    take = rd_uart;
    @(posedge clk);
    #1;
    if (take && src.size() > 0) void'(src.pop_front());
    refresh();
  end

  // Output monitor and consume tracker.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (pkt_valid || pkt_err) begin
      tests++;
      assert (!(pkt_valid && pkt_err)) else begin
        fails++;
        $error("FAIL both_strobes: valid=%0b err=%0b expected only one", pkt_valid, pkt_err);
      end
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_strobe: valid=%0b err=%0b type=%b, none expected",
               pkt_valid, pkt_err, err_type);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("strobe_kind_err", pkt_err, e.is_err);
        check("pkt_data", pkt_data, e.data);
        if (e.is_err) check("err_type", err_type, e.et);
        check("strobe_latency", cyc - last_rd, e.lat);
      end
    end
    if (rd_uart) begin
      tests++;
      assert (cyc - last_rd >= 2) else begin
        fails++;
        $error("FAIL consume_spacing: gap %0d expected >= 2", cyc - last_rd);
      end
      last_rd = cyc;
      rd_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int n0;
    int k;
    reset    = 1'b1;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    send(8'h33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rd_uart", rd_uart, 0);
    check("reset_pkt_data", pkt_data, 0);
    check("reset_pkt_valid", pkt_valid, 0);
    check("reset_pkt_err", pkt_err, 0);
    check("reset_err_type", err_type, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    drain();

    // 1: good packet at full throughput
    p = cyc;
    send(8'hA5); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h14);
    expect_pkt(32'h12345678);
    drain();
    check("t1_throughput_last_consume", last_rd, p + 10);
    check("t1_pkt_data_held", pkt_data, 32'h12345678);

    // 2: checksum error keeps pkt_data, then recovery
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hFF);
    expect_err(2'b01, 1);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h01); send(8'h01);
    expect_pkt(32'h00000001);
    drain();
    check("t2_pkt_data", pkt_data, 32'h00000001);

    // 3: leading junk is consumed and dropped
    n0 = rd_count;
    send(8'h00); send(8'hFF); send(8'h5A);
    send(8'hA5); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'h0E);
    expect_pkt(32'hAABBCCDD);
    drain();
    check("t3_consumed", rd_count - n0, 9);

    // 4: timeout mid-frame, then a clean frame
    send(8'hA5); send(8'h11); send(8'h22);
    expect_err(2'b10, TO + 1);
    drain();
    check("t4_err_type_held", err_type, 2'b10);
    send(8'hA5); send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'hA0);
    expect_pkt(32'h10203040);
    drain();

    // 5: consume in the expiry cycle beats the timeout
    send(8'hA5); send(8'h11); send(8'h22);
    wait_src_empty();
    k = 0;
    while (cyc != last_rd + TO && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("t5_wait_bound", (k < 100), 1);
    send(8'h33); send(8'h44); send(8'hAA);
    expect_pkt(32'h11223344);
    @(negedge clk);
    check("t5_consume_at_expiry", rd_uart, 1);
    drain();

    // 6: reset mid-frame; pending byte survives the reset cycle
    send(8'hA5); send(8'h11);
    wait_src_empty();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    send(8'hA5);
    @(negedge clk);
    check("t6_rd_uart_in_reset", rd_uart, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    good  = 32'h0;
    check("t6_pkt_data_reset", pkt_data, 0);
    check("t6_err_type_reset", err_type, 0);
    check("t6_pkt_valid_reset", pkt_valid, 0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h0A);
    expect_pkt(32'h01020304);
    drain();
    check("t6_pkt_data", pkt_data, 32'h01020304);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
